instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter INS_WIDTH, default 32, instruction word width.
REQ-002 SHALL have parameter PC_WIDTH, default 10, word-address width of instruction memory.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, fetch buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port imem_en  output  1  read strobe to synchronous instruction ROM.
REQ-007 SHALL have port imem_addr  output  PC_WIDTH  word address of the read.
REQ-008 SHALL have port imem_dout  input  INS_WIDTH  ROM data, valid exactly one cycle after imem_en.
REQ-009 SHALL have port IR  output  INS_WIDTH  instruction presented to controller.
REQ-010 SHALL have port ir_valid  output  1  IR/ir_pc hold a valid instruction.
REQ-011 SHALL have port ir_ready  input  1  controller accepts IR this cycle.
REQ-012 SHALL have port ir_pc  output  PC_WIDTH  address of the instruction on IR.
REQ-013 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-014 SHALL have port redirect_pc  input  PC_WIDTH  target address, sampled when redirect=1.
REQ-015 SHALL have port halt  input  1  level; stop issuing new fetches.

Function
REQ-016 SHALL transfer an instruction only on a cycle with ir_valid=1 and ir_ready=1 (pop).
REQ-017 SHALL hold IR, ir_pc and ir_valid stable while ir_valid=1 and ir_ready=0, absent redirect.
REQ-018 SHALL implement FSM states RUN and HALTED; RUN->HALTED when halt=1, HALTED->RUN when halt=0.
REQ-019 SHALL assert imem_en only in RUN, redirect=0, and (count + inflight - pop) < FIFO_DEPTH.
REQ-020 SHALL drive imem_addr = PC and post-increment PC on each issued fetch; PC wraps 2^PC_WIDTH-1 -> 0.
REQ-021 SHALL track one in-flight read; on its return push {imem_dout, issued address} into the FIFO.
REQ-022 SHALL present the FIFO head on IR/ir_pc; ir_valid = (count != 0).
REQ-023 SHALL, with empty FIFO, give latency 2 cycles from imem_en to ir_valid (fetch at N, data at N+1, ir_valid at N+2).
REQ-024 SHALL sustain one instruction per cycle when ir_ready is held high.
REQ-025 SHALL on redirect=1: empty FIFO, discard any in-flight return, set PC = redirect_pc, issue no fetch that cycle.
REQ-026 SHALL treat a pop coinciding with redirect as completed; flush still applies to the rest.
REQ-027 SHALL give redirect priority over halt; PC still updates when HALTED.
REQ-028 SHALL in HALTED keep FIFO contents poppable and still capture an in-flight return.
REQ-029 SHALL never push when full; the credit rule of REQ-019 guarantees no overflow.
REQ-030 SHALL simultaneously push and pop on a full FIFO without loss (count unchanged).

Reset
REQ-031 SHALL on rst=1 asynchronously set PC=0, count=0, inflight=0, state=RUN.
REQ-032 SHALL hold outputs during reset at imem_en=0, imem_addr=0, IR=0, ir_pc=0, ir_valid=0.
REQ-033 SHALL on reset mid-operation drop the in-flight read and FIFO contents; first fetch (addr 0) on the first edge after rst deasserts.

Structure
REQ-034 SHALL place INS_WIDTH, PC_WIDTH defaults and the FSM state encoding in shared package mips_pkg.
REQ-035 SHALL implement the buffer as sub-module fetch_fifo (synchronous, push/pop/flush, count output).

Verification
REQ-036 SHALL cover: reset release, ir_ready=1, ROM[i]=i+100 -> imem_en at cycle 0, IR=100 ir_pc=0 valid at cycle 2, then 101,102 each cycle.
REQ-037 SHALL cover: ir_ready=0 for 5 cycles -> exactly 2 fetches issued, IR stays 100, no imem_en after FIFO+inflight=2; on ir_ready=1 sequence resumes 100,101,102 without gap or loss.
REQ-038 SHALL cover: redirect=1 redirect_pc=0x040 while in-flight and FIFO nonempty -> ir_valid=0 next cycle, imem_addr=0x040 next cycle, next valid IR has ir_pc=0x040.
REQ-039 SHALL cover: PC=0x3FF (PC_WIDTH=10) -> next fetch addr 0x000, ir_pc sequence 0x3FF,0x000.
REQ-040 SHALL cover: halt=1 for 6 cycles with ir_ready=1 -> buffered instructions drain, no imem_en, ir_valid=0; halt=0 -> fetch resumes at next sequential PC.
REQ-041 SHALL cover: rst pulse asserted mid-stream between clock edges -> outputs zero immediately, first post-reset IR has ir_pc=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: default widths and fetch FSM encoding.
// Imported by instr_fetch.
package mips_pkg;

  localparam int INS_WIDTH_DEF = 32;
  localparam int PC_WIDTH_DEF  = 10;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: synchronous FIFO with push/pop/flush and occupancy count.
// Ports: clk, rst, push, pop, flush, din -> dout (head), count.
module fetch_fifo #(
  parameter int W     = 42,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    // a pop on a full buffer frees the slot for a same-cycle push
    do_push = push && ((cnt_q != (AW+1)'(DEPTH)) || do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + (AW+1)'(do_push)
                    - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, sync-ROM read issue, fetch buffer, redirect/halt.
// Ports: clk, rst, imem_en/addr/dout, IR/ir_pc/ir_valid/ir_ready,
// redirect/redirect_pc, halt.
module instr_fetch
  import mips_pkg::*;
#(
  parameter int INS_WIDTH  = INS_WIDTH_DEF,
  parameter int PC_WIDTH   = PC_WIDTH_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_en,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic [INS_WIDTH-1:0] imem_dout,
  output logic [INS_WIDTH-1:0] IR,
  output logic                 ir_valid,
  input  logic                 ir_ready,
  output logic [PC_WIDTH-1:0]  ir_pc,
  input  logic                 redirect,
  input  logic [PC_WIDTH-1:0]  redirect_pc,
  input  logic                 halt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                infl_q, infl_d;
  logic [PC_WIDTH-1:0] infl_addr_q, infl_addr_d;

  logic [CW-1:0]       count;
  logic [CW:0]         occ;
  logic                pop, push;
  logic [INS_WIDTH-1:0] head_ins;
  logic [PC_WIDTH-1:0]  head_pc;

  assign ir_valid = (count != '0);
  assign pop      = ir_valid && ir_ready;
  // a redirect discards the returning read
  assign push     = infl_q && !redirect;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:    if (halt)  state_d = HALTED;
      HALTED: if (!halt) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    // slots already owed: buffered + returning, minus this pop
    occ = {1'b0, count}
        + (CW+1)'(infl_q)
        - (CW+1)'(pop);
    imem_en = !rst && (state_q == RUN) && !halt
           && !redirect && (occ < (CW+1)'(FIFO_DEPTH));
    pc_d        = pc_q;
    infl_d      = imem_en;
    infl_addr_d = infl_addr_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (imem_en) begin
      pc_d        = pc_q + 1'b1;
      infl_addr_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= '0;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      infl_q      <= infl_d;
      infl_addr_q <= infl_addr_d;
    end
  end

  fetch_fifo #(
    .W     (INS_WIDTH + PC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({imem_dout, infl_addr_q}),
    .dout  ({head_ins, head_pc}),
    .count (count)
  );

  assign imem_addr = pc_q;
  // empty-buffer head is stale storage; show zeros instead
  assign IR        = ir_valid ? head_ins : '0;
  assign ir_pc     = ir_valid ? head_pc  : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: ROM[i]=i+100, scoreboard of expected IR stream.
// Directed phases: startup, backpressure, redirect, wrap, halt, reset.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_dout = '0;
  logic [31:0] IR;
  logic        ir_valid;
  logic        ir_ready;
  logic [9:0]  ir_pc;
  logic        redirect;
  logic [9:0]  redirect_pc;
  logic        halt;

  int total = 0;
  int bad   = 0;
  int n;

  typedef struct {
    logic [31:0] ins;
    logic [9:0]  pc;
  } exp_t;

  exp_t sbq[$];

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_dout   (imem_dout),
    .IR          (IR),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .ir_pc       (ir_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_en) imem_dout <= 32'(imem_addr) + 32'd100;
  end

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sb_restart(logic [9:0] start);
    exp_t e;
    logic [9:0] p;
    sbq.delete();
    p = start;
    for (int i = 0; i < 64; i++) begin
      e.pc  = p;
      e.ins = 32'(p) + 32'd100;
      sbq.push_back(e);
      p = p + 10'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(string tag, int lim);
    int k = 0;
    while (!ir_valid && k < lim) begin
      tick();
      k++;
    end
    chk(tag, 32'(ir_valid), 32'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && ir_valid && ir_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_pc", 32'(ir_pc), 32'(e.pc));
        chk("sb_ir", IR, e.ins);
      end
    end
  end

  initial begin
    rst = 1'b1;
    ir_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    halt = 1'b0;
    #2;
    chk("rst_en",    32'(imem_en),   32'd0);
    chk("rst_addr",  32'(imem_addr), 32'd0);
    chk("rst_ir",    IR,             32'd0);
    chk("rst_pc",    32'(ir_pc),     32'd0);
    chk("rst_valid", 32'(ir_valid),  32'd0);

    // startup latency and full throughput
    sb_restart(10'd0);
    ir_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t1_en0",   32'(imem_en),   32'd1);
    chk("t1_addr0", 32'(imem_addr), 32'd0);
    tick();
    chk("t1_c1_valid", 32'(ir_valid), 32'd0);
    tick();
    chk("t1_c2_valid", 32'(ir_valid), 32'd1);
    chk("t1_c2_ir",    IR,            32'd100);
    chk("t1_c2_pc",    32'(ir_pc),    32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_stream", 32'(ir_valid), 32'd1);
    end

    // backpressure from reset
    ir_ready = 1'b0;
    rst = 1'b1;
    tick();
    sb_restart(10'd0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n += int'(imem_en);
      tick();
    end
    chk("t2_fetches", 32'(n),       32'd2);
    chk("t2_ir",      IR,           32'd100);
    chk("t2_pc",      32'(ir_pc),   32'd0);
    chk("t2_en",      32'(imem_en), 32'd0);
    ir_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_nogap", 32'(ir_valid), 32'd1);
    end

    // redirect with buffer and read in flight
    chk("t3_pre_valid", 32'(ir_valid), 32'd1);
    redirect = 1'b1;
    redirect_pc = 10'h040;
    #1;
    chk("t3_en_redir", 32'(imem_en), 32'd0);
    tick();
    sb_restart(10'h040);
    redirect = 1'b0;
    #1;
    chk("t3_valid0", 32'(ir_valid),  32'd0);
    chk("t3_addr",   32'(imem_addr), 32'h040);
    chk("t3_en",     32'(imem_en),   32'd1);
    tick();
    tick();
    chk("t3_valid", 32'(ir_valid), 32'd1);
    chk("t3_pc",    32'(ir_pc),    32'h040);

    // PC wrap
    redirect = 1'b1;
    redirect_pc = 10'h3FF;
    tick();
    sb_restart(10'h3FF);
    redirect = 1'b0;
    #1;
    chk("t4_addr_top", 32'(imem_addr), 32'h3FF);
    tick();
    chk("t4_addr_wrap", 32'(imem_addr), 32'h000);
    chk("t4_en_wrap",   32'(imem_en),   32'd1);
    wait_valid("t4_wait", 5);
    chk("t4_pc_top", 32'(ir_pc), 32'h3FF);
    tick();
    chk("t4_pc_wrap", 32'(ir_pc), 32'h000);
    repeat (3) tick();

    // halt drains the buffer and stops fetching
    halt = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n += int'(imem_en);
      tick();
    end
    chk("t5_fetches", 32'(n),        32'd0);
    chk("t5_valid",   32'(ir_valid), 32'd0);
    halt = 1'b0;
    wait_valid("t5_resume", 6);
    repeat (4) tick();

    // asynchronous reset mid-stream
    #2;
    rst = 1'b1;
    #1;
    chk("t6_en",    32'(imem_en),   32'd0);
    chk("t6_addr",  32'(imem_addr), 32'd0);
    chk("t6_ir",    IR,             32'd0);
    chk("t6_pc",    32'(ir_pc),     32'd0);
    chk("t6_valid", 32'(ir_valid),  32'd0);
    sb_restart(10'd0);
    tick();
    rst = 1'b0;
    wait_valid("t6_wait", 5);
    chk("t6_first_pc", 32'(ir_pc), 32'd0);
    chk("t6_first_ir", IR,         32'd100);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
